usb_ep_engine: RTL and testbench
================================

# usb_ep_engine

Controller-side endpoint engine for the USB device core. It turns decoded IN/OUT tokens and packet bytes from the packet layer into the per-endpoint handshake (`txact`/`txpop`/`txval`/`txcork`/`txdat`/`txdat_len` and `rxact`/`rxval`/`rxrdy`/`rxdat`) that endpoint function blocks implement. It sits between the packet decoder/serializer and the endpoint function blocks, which it services one transaction at a time.

## Interface
- `MAX_PKT`, 64: maximum data payload in bytes; `txdat_len` is clipped to this value.
- `EP_MASK`, 16'h0001: bit n set means endpoint n is served.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tok_vld` in 1: one-cycle token strobe.
- `tok_in` in 1: 1 means IN token, 0 means OUT token.
- `tok_ep` in 4: token endpoint number.
- `endpt` out 4: endpoint of the current transaction.
- `txact` out 1: IN transaction active.
- `txpop` out 1: one-cycle pulse that advances the endpoint's tx byte.
- `txval`, `txcork` in 1: endpoint data valid / endpoint has nothing to send.
- `txdat` in 8, `txdat_len` in 12: current tx byte / IN payload length.
- `pk_tx_vld` out 1, `pk_tx_dat` out 8, `pk_tx_last` out 1, `pk_tx_rdy` in 1: byte stream to the serializer.
- `pk_tx_zlp` out 1, `pk_tx_nak` out 1: one-cycle pulses requesting a zero-length packet or a NAK.
- `pk_rx_vld` in 1, `pk_rx_dat` in 8, `pk_rx_last` in 1: OUT data bytes from the decoder; no backpressure.
- `rxact` out 1, `rxval` out 1, `rxdat` out 8, `rxrdy` in 1: byte stream to the endpoint.
- `pk_rx_ack` out 1, `pk_rx_nak` out 1: one-cycle handshake result after the last OUT byte.

## Operation
- **Reset values:** all outputs are 0. The FSM is in IDLE and the counters are cleared.
- **FSM states:** IDLE, IN_REQ, IN_FETCH, IN_SEND, OUT_DATA, OUT_DONE.
- **Token handling in IDLE:**
  - `tok_vld` with `EP_MASK[tok_ep]`=0 is ignored; the FSM stays in IDLE.
  - `tok_vld` while not in IDLE is ignored.
  - On an accepted token, `endpt` latches `tok_ep` and the FSM moves to IN_REQ (`tok_in`=1) or OUT_DATA.
- **IN_REQ:**
  - `txact`=1 from this state until the IN transaction ends.
  - In the next cycle the engine samples `txcork` and `txdat_len`.
  - `txcork`=1: pulse `pk_tx_nak`, go to IDLE.
  - Otherwise load `remain` = min(`txdat_len`, `MAX_PKT`).
  - `remain`=0: pulse `pk_tx_zlp`, go to IDLE.
  - `remain`>0: go to IN_FETCH.
- **IN_FETCH:** wait one cycle for `txdat`, then register it into `pk_tx_dat` and go to IN_SEND.
- **IN_SEND:**
  - Hold `pk_tx_vld`=1 with `pk_tx_last` = (`remain`==1) until `pk_tx_rdy`.
  - On acceptance, pulse `txpop` and decrement `remain`.
  - `remain` was 1: drop `txact`, go to IDLE. Otherwise go to IN_FETCH.
- **OUT_DATA:**
  - `rxact`=1 throughout.
  - Each `pk_rx_vld` byte is forwarded as `rxval`=1 / `rxdat` for one cycle.
  - If `rxrdy`=0 at byte arrival (non-FIFO build), the byte is dropped and the sticky `err` flag is set.
  - Bytes beyond `MAX_PKT` also set `err`.
  - `pk_rx_last` moves the FSM to OUT_DONE.
- **OUT_DONE:**
  - Pulse `pk_rx_ack` if `err`=0, else `pk_rx_nak`. Exactly one of the two pulses per OUT transaction.
  - Clear `err`, drop `rxact`, go to IDLE.
- **Byte counter:** 12 bits, saturating; it does not wrap.
- **Reset mid-transaction:** immediate return to IDLE with all outputs at 0. No handshake pulse is produced for the aborted transaction.

## Timing
- Token to `txact`=1: 1 cycle.
- `txact` to `txdat_len`/`txcork` sample: 1 cycle.
- `txpop` to next valid `txdat`: 1 cycle.
- IN throughput: at most 1 byte per 2 cycles.
- `pk_rx_vld` to `rxval`: 1 cycle, registered.
- `pk_rx_last` to `pk_rx_ack`/`pk_rx_nak`: 2 cycles (FIFO build: after the FIFO drains, plus 1 cycle).
- `txval` is not used for flow control; `txcork` and `txdat_len` alone define the IN payload.

## Configuration
- **`USB_EP_OUT_FIFO_EN` defined:**
  - An 8-deep byte FIFO sits between `pk_rx_*` and `rx*`.
  - `rxval` is asserted while the FIFO is non-empty and `rxrdy`=1.
  - `err` is set only on FIFO overflow (a write while full) or on exceeding `MAX_PKT`.
  - OUT_DONE waits until the FIFO is empty.
- **Undefined:** direct path as described in Operation; `rxrdy`=0 at byte arrival means the byte is dropped and the packet is NAKed.

## Structure
- **Package `usb_ep_pkg`:**
  - State enum `ep_state_t`.
  - PID constants: `PID_IN`, `PID_OUT`, `PID_ACK`, `PID_NAK`.
  - Default `MAX_PKT_DEF`=64.
- **Sub-module `ep_byte_fifo`:** parameterized depth, 8-bit data, with full/empty outputs. Instantiated only under `USB_EP_OUT_FIFO_EN`.

## Test plan
- **IN, 3 bytes:** IN token on ep0 with `txdat_len`=3 and bytes 0xA1, 0xA2, 0xA3, `pk_tx_rdy`=1 → `pk_tx_dat` 0xA1, 0xA2, 0xA3; `pk_tx_last` only on 0xA3; 3 `txpop` pulses; `txact` drops afterwards.
- **IN, corked / empty:** IN token with `txcork`=1 → one `pk_tx_nak`, no `txpop`. With `txdat_len`=0 → one `pk_tx_zlp`.
- **IN, clipping and backpressure:** `txdat_len`=100, `MAX_PKT`=64, `pk_tx_rdy` toggling every other cycle → exactly 64 bytes sent, last flagged, no byte duplicated or skipped.
- **OUT, clean:** 4-byte OUT packet 0x10–0x13 with `rxrdy`=1 → 4 `rxval` pulses carrying 0x10–0x13, then `pk_rx_ack`.
- **OUT, stalled endpoint:** `rxrdy`=0 on the 2nd byte → non-FIFO build gives `pk_rx_nak`; FIFO build with a 3-cycle stall gives all bytes delivered and `pk_rx_ack`.
- **Filtering and reset:** token on ep5 with `EP_MASK`=1 → no activity. `rst` asserted mid-IN_SEND → all outputs 0 at once; the next token is processed normally.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the USB endpoint engine.
package usb_ep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_REQ,
    IN_FETCH,
    IN_SEND,
    OUT_DATA,
    OUT_DONE
  } ep_state_t;

  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  localparam int MAX_PKT_DEF = 64;

  function automatic logic [11:0] clip_len(input logic [11:0] len, input logic [11:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ep_byte_fifo.sv
// Small byte FIFO with registered occupancy; full/empty never depend on same-cycle inputs.
// DEPTH must be a power of two so the pointers wrap naturally.
module ep_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_dat,
  input  logic       rd_en,
  output logic [7:0] rd_dat,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
    else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/usb_ep_engine.sv
// Endpoint transaction engine: token -> IN byte pump or OUT byte forwarder with ACK/NAK.
// Define USB_EP_OUT_FIFO_EN to place an 8-deep elastic buffer on the OUT path.
module usb_ep_engine
  import usb_ep_pkg::*;
#(
  parameter int          MAX_PKT = MAX_PKT_DEF,
  parameter logic [15:0] EP_MASK = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tok_vld,
  input  logic        tok_in,
  input  logic [3:0]  tok_ep,
  output logic [3:0]  endpt,
  output logic        txact,
  output logic        txpop,
  input  logic        txval,
  input  logic        txcork,
  input  logic [7:0]  txdat,
  input  logic [11:0] txdat_len,
  output logic        pk_tx_vld,
  output logic [7:0]  pk_tx_dat,
  output logic        pk_tx_last,
  input  logic        pk_tx_rdy,
  output logic        pk_tx_zlp,
  output logic        pk_tx_nak,
  input  logic        pk_rx_vld,
  input  logic [7:0]  pk_rx_dat,
  input  logic        pk_rx_last,
  output logic        rxact,
  output logic        rxval,
  output logic [7:0]  rxdat,
  input  logic        rxrdy,
  output logic        pk_rx_ack,
  output logic        pk_rx_nak
);
  localparam logic [11:0] MAX_LEN = 12'(MAX_PKT);

  ep_state_t   state_q, state_d;
  logic [3:0]  endpt_q, endpt_d;
  logic [11:0] remain_q, remain_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic        tx_nak_q, tx_nak_d;
  logic        tx_zlp_q, tx_zlp_d;
  logic        rx_ack_q, rx_ack_d;
  logic        rx_nak_q, rx_nak_d;
  logic        over_len, rx_drop, out_drained, out_wr;
  logic        unused_txval;

  // Payload length comes from txcork/txdat_len alone; txval carries no flow control.
  assign unused_txval = txval;

  assign over_len = (cnt_q >= MAX_LEN);
  assign out_wr   = (state_q == OUT_DATA) && pk_rx_vld && !over_len;

`ifdef USB_EP_OUT_FIFO_EN
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dat;

  ep_byte_fifo #(.DEPTH(8)) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (out_wr),
    .wr_dat (pk_rx_dat),
    .rd_en  (rxval),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign rxval       = !fifo_empty && rxrdy;
  assign rxdat       = fifo_empty ? 8'h00 : fifo_dat;
  assign rx_drop     = fifo_full;
  assign out_drained = fifo_empty;
`else
  logic       rxval_q, rxval_d;
  logic [7:0] rxdat_q, rxdat_d;

  // A byte the endpoint cannot take on arrival is lost; the packet gets NAKed.
  always_comb begin
    rxval_d = out_wr && rxrdy;
    rxdat_d = rxval_d ? pk_rx_dat : rxdat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxval_q <= 1'b0;
      rxdat_q <= 8'h00;
    end else begin
      rxval_q <= rxval_d;
      rxdat_q <= rxdat_d;
    end
  end

  assign rxval       = rxval_q;
  assign rxdat       = rxdat_q;
  assign rx_drop     = !rxrdy;
  assign out_drained = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    endpt_d  = endpt_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tx_dat_d = tx_dat_q;
    tx_nak_d = 1'b0;
    tx_zlp_d = 1'b0;
    rx_ack_d = 1'b0;
    rx_nak_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tok_vld && EP_MASK[tok_ep]) begin
          endpt_d = tok_ep;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = tok_in ? IN_REQ : OUT_DATA;
        end
      end
      IN_REQ: begin
        if (txcork) begin
          tx_nak_d = 1'b1;
          state_d  = IDLE;
        end else begin
          remain_d = clip_len(txdat_len, MAX_LEN);
          if (remain_d == '0) begin
            tx_zlp_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = IN_FETCH;
          end
        end
      end
      IN_FETCH: begin
        tx_dat_d = txdat;
        state_d  = IN_SEND;
      end
      IN_SEND: begin
        if (pk_tx_rdy) begin
          remain_d = remain_q - 12'd1;
          state_d  = (remain_q == 12'd1) ? IDLE : IN_FETCH;
        end
      end
      OUT_DATA: begin
        if (pk_rx_vld) begin
          if (cnt_q != 12'hFFF) cnt_d = cnt_q + 12'd1;
          if (over_len || rx_drop) err_d = 1'b1;
        end
        if (pk_rx_last) state_d = OUT_DONE;
      end
      OUT_DONE: begin
        if (out_drained) begin
          rx_ack_d = !err_q;
          rx_nak_d = err_q;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      endpt_q  <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tx_dat_q <= '0;
      tx_nak_q <= 1'b0;
      tx_zlp_q <= 1'b0;
      rx_ack_q <= 1'b0;
      rx_nak_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      endpt_q  <= endpt_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tx_dat_q <= tx_dat_d;
      tx_nak_q <= tx_nak_d;
      tx_zlp_q <= tx_zlp_d;
      rx_ack_q <= rx_ack_d;
      rx_nak_q <= rx_nak_d;
    end
  end

  assign endpt      = endpt_q;
  assign txact      = (state_q == IN_REQ) || (state_q == IN_FETCH) || (state_q == IN_SEND);
  assign pk_tx_vld  = (state_q == IN_SEND);
  assign pk_tx_last = pk_tx_vld && (remain_q == 12'd1);
  assign txpop      = pk_tx_vld && pk_tx_rdy;
  assign pk_tx_dat  = tx_dat_q;
  assign pk_tx_nak  = tx_nak_q;
  assign pk_tx_zlp  = tx_zlp_q;
  assign rxact      = (state_q == OUT_DATA) || (state_q == OUT_DONE);
  assign pk_rx_ack  = rx_ack_q;
  assign pk_rx_nak  = rx_nak_q;

endmodule

// File: tb/tb_usb_ep_engine.sv
// Scoreboard bench for usb_ep_engine: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_usb_ep_engine;
  localparam int          MAXP    = 64;
  localparam logic [15:0] MASK    = 16'h0001;
  localparam int          HS_ACK  = 0;
  localparam int          HS_NAK  = 1;
  localparam int          HS_TXNAK = 2;
  localparam int          HS_ZLP  = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tok_vld, tok_in;
  logic [3:0]  tok_ep, endpt;
  logic        txact, txpop, txval, txcork;
  logic [7:0]  txdat;
  logic [11:0] txdat_len;
  logic        pk_tx_vld, pk_tx_last, pk_tx_rdy, pk_tx_zlp, pk_tx_nak;
  logic [7:0]  pk_tx_dat;
  logic        pk_rx_vld, pk_rx_last;
  logic [7:0]  pk_rx_dat;
  logic        rxact, rxval, rxrdy, pk_rx_ack, pk_rx_nak;
  logic [7:0]  rxdat;

  usb_ep_engine #(.MAX_PKT(MAXP), .EP_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .tok_vld(tok_vld), .tok_in(tok_in), .tok_ep(tok_ep),
    .endpt(endpt), .txact(txact), .txpop(txpop), .txval(txval), .txcork(txcork),
    .txdat(txdat), .txdat_len(txdat_len), .pk_tx_vld(pk_tx_vld), .pk_tx_dat(pk_tx_dat),
    .pk_tx_last(pk_tx_last), .pk_tx_rdy(pk_tx_rdy), .pk_tx_zlp(pk_tx_zlp), .pk_tx_nak(pk_tx_nak),
    .pk_rx_vld(pk_rx_vld), .pk_rx_dat(pk_rx_dat), .pk_rx_last(pk_rx_last), .rxact(rxact),
    .rxval(rxval), .rxdat(rxdat), .rxrdy(rxrdy), .pk_rx_ack(pk_rx_ack), .pk_rx_nak(pk_rx_nak)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] dat; logic last; } txb_t;
  txb_t       exp_tx[$];
  logic [7:0] exp_rx[$];
  int         exp_hs[$];
  int         checks = 0, errors = 0;
  int         rdy_mode = 0;

  // Endpoint-side tx source: a byte ring advanced by txpop.
  logic [7:0] tx_buf [256];
  logic [7:0] tx_idx = 8'h00;
  assign txdat = tx_buf[tx_idx];
  always @(posedge clk) if (txpop) tx_idx <= tx_idx + 8'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({endpt, txact, txpop, pk_tx_vld, pk_tx_dat, pk_tx_last, pk_tx_zlp, pk_tx_nak,
                rxact, rxval, rxdat, pk_rx_ack, pk_rx_nak});
  endfunction

  task automatic hs_seen(input int code);
    int e;
    if (exp_hs.size() == 0) chk("hs_unexpected", 32'(exp_hs.size()), 32'd1);
    else begin
      e = exp_hs.pop_front();
      chk("handshake", 32'(code), 32'(e));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pk_tx_vld && pk_tx_rdy) begin
          if (exp_tx.size() == 0) chk("tx_unexpected", 32'(exp_tx.size()), 32'd1);
          else begin
            txb_t e;
            e = exp_tx.pop_front();
            chk("tx_dat", 32'(pk_tx_dat), 32'(e.dat));
            chk("tx_last", 32'(pk_tx_last), 32'(e.last));
          end
        end
        if (txpop || (pk_tx_vld && pk_tx_rdy)) chk("txpop", 32'(txpop), 32'(pk_tx_vld && pk_tx_rdy));
        if (rxval) begin
          if (exp_rx.size() == 0) chk("rx_unexpected", 32'(exp_rx.size()), 32'd1);
          else begin
            logic [7:0] d;
            d = exp_rx.pop_front();
            chk("rx_dat", 32'(rxdat), 32'(d));
          end
        end
        if (pk_rx_ack) hs_seen(HS_ACK);
        if (pk_rx_nak) hs_seen(HS_NAK);
        if (pk_tx_nak) hs_seen(HS_TXNAK);
        if (pk_tx_zlp) hs_seen(HS_ZLP);
      end
    end
  end

  initial begin
    pk_tx_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pk_tx_rdy = 1'b1;
        1:       pk_tx_rdy = ~pk_tx_rdy;
        2:       pk_tx_rdy = 1'($urandom_range(0, 1));
        default: pk_tx_rdy = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic token(input logic in_tok, input logic [3:0] ep);
    tok_vld = 1'b1; tok_in = in_tok; tok_ep = ep;
    step();
    tok_vld = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_tx.size() + exp_rx.size() + exp_hs.size()) != 0 && k < 3000) begin
      step(); k++;
    end
    chk("drain_pending", 32'(exp_tx.size() + exp_rx.size() + exp_hs.size()), 32'd0);
    exp_tx.delete(); exp_rx.delete(); exp_hs.delete();
    repeat (4) step();
    chk("txact_idle", 32'(txact), 32'd0);
    chk("rxact_idle", 32'(rxact), 32'd0);
  endtask

  task automatic send_in(input logic [3:0] ep, input logic cork, input int len, input int mode);
    logic [15:0] m = MASK;
    logic [7:0]  start = tx_idx;
    int          n;
    txcork = cork; txdat_len = 12'(len); rdy_mode = mode;
    if (m[ep]) begin
      n = (len > MAXP) ? MAXP : len;
      if (cork) exp_hs.push_back(HS_TXNAK);
      else if (n == 0) exp_hs.push_back(HS_ZLP);
      else for (int k = 0; k < n; k++) exp_tx.push_back({tx_buf[8'(start + k)], k == n - 1});
    end
    token(1'b1, ep);
    drain();
  endtask

  task automatic send_out(input logic [3:0] ep, input int n, input int base, input int stall_at,
                          input int stall_len, input bit inject);
    logic [15:0] m = MASK;
    logic [7:0]  d;
    logic        rdy;
    bit          err = 0;
    token(1'b0, ep);
    for (int i = 0; i < n; i++) begin
      d   = (base >= 0) ? 8'(base + i) : 8'($urandom);
      rdy = !(i >= stall_at && i < stall_at + stall_len);
      rxrdy = rdy; pk_rx_vld = 1'b1; pk_rx_dat = d; pk_rx_last = (i == n - 1);
      if (inject && i == 1) begin tok_vld = 1'b1; tok_in = 1'b1; tok_ep = 4'd0; end
      if (m[ep]) begin
`ifdef USB_EP_OUT_FIFO_EN
        if (i < MAXP) exp_rx.push_back(d); else err = 1;
`else
        if (rdy && i < MAXP) exp_rx.push_back(d); else err = 1;
`endif
      end
      step();
      tok_vld = 1'b0;
    end
    pk_rx_vld = 1'b0; pk_rx_last = 1'b0; rxrdy = 1'b1;
    if (m[ep]) exp_hs.push_back(err ? HS_NAK : HS_ACK);
    drain();
  endtask

  initial begin
    logic [7:0] s;
    tok_vld = 0; tok_in = 0; tok_ep = 0; txval = 1; txcork = 0; txdat_len = 0;
    pk_rx_vld = 0; pk_rx_dat = 0; pk_rx_last = 0; rxrdy = 1;
    foreach (tx_buf[i]) tx_buf[i] = 8'($urandom);

    #12 chk("reset_outputs", outs(), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) step();

    s = tx_idx;
    tx_buf[s] = 8'hA1; tx_buf[8'(s + 1)] = 8'hA2; tx_buf[8'(s + 2)] = 8'hA3;
    send_in(4'd0, 1'b0, 3, 0);
    send_in(4'd0, 1'b1, 10, 0);
    send_in(4'd0, 1'b0, 0, 0);
    send_in(4'd0, 1'b0, 100, 1);
    send_in(4'd0, 1'b0, 64, 2);

    send_out(4'd0, 4, 8'h10, 99, 0, 0);
    send_out(4'd0, 6, -1, 1, 3, 0);
    send_out(4'd0, 64, -1, 99, 0, 0);
    send_out(4'd0, 65, -1, 99, 0, 0);
    send_out(4'd0, 5, -1, 99, 0, 1);

    send_in(4'd5, 1'b0, 5, 0);
    send_out(4'd5, 4, -1, 99, 0, 0);

    // Abort an IN while it is held in the send state.
    txcork = 1'b0; txdat_len = 12'd20; rdy_mode = 3;
    token(1'b1, 4'd0);
    for (int k = 0; k < 20 && !pk_tx_vld; k++) step();
    chk("reached_in_send", 32'(pk_tx_vld), 32'd1);
    rst = 1'b1; #1;
    chk("reset_mid_outputs", outs(), 32'd0);
    step(); rst = 1'b0; rdy_mode = 0;
    step();
    send_in(4'd0, 1'b0, 5, 2);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] ep;
      ep = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 1) == 1)
        send_in(ep, 1'($urandom_range(0, 7) == 0), $urandom_range(0, 80), $urandom_range(0, 2));
      else
        send_out(ep, $urandom_range(1, 70), -1, $urandom_range(0, 8), $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
